npu_bias_ctrl: RTL and testbench

NPU_BIAS_CTRL -- requirements
Module: npu_bias_ctrl

---
 rtl/npu_pkg.sv | 12 +
 rtl/npu_bi_o.sv | 12 +
 rtl/npu_bias_ctrl.sv | 130 +++++++++++++
 tb/tb_npu_bias_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath width and the bias controller state encoding.
package npu_pkg;

    localparam int M_LEN = 16;

    typedef enum logic [1:0] {
        BIAS_IDLE = 2'd0,
        BIAS_RUN  = 2'd1,
        BIAS_DONE = 2'd2
    } npu_bias_state_t;

endpackage

// File: rtl/npu_bi_o.sv
// Combinational bias adder: full-precision (M_LEN+1 bit) sum so the caller decides wrap or clamp.
module npu_bi_o
    import npu_pkg::*;
(
    input  logic signed [M_LEN-1:0] data_i,
    input  logic signed [M_LEN-1:0] bias_i,
    output logic signed [M_LEN:0]   sum_o
);

    assign sum_o = {data_i[M_LEN-1], data_i} + {bias_i[M_LEN-1], bias_i};

endmodule

// File: rtl/npu_bias_ctrl.sv
// Per-channel bias controller: adds bias[ch] to a channel-major result stream, one-cycle registered output.
// Optional clamping of the sum is enabled by defining NPU_BIAS_SAT_EN; otherwise the sum wraps.
module npu_bias_ctrl
    import npu_pkg::*;
#(
    parameter  int BIAS_DEPTH = 16,
    parameter  int CNT_W      = 16,
    localparam int AW         = $clog2(BIAS_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    bias_we_i,
    input  logic [AW-1:0]           bias_waddr_i,
    input  logic signed [M_LEN-1:0] bias_wdata_i,
    input  logic                    start_i,
    input  logic [AW:0]             num_ch_i,
    input  logic [CNT_W-1:0]        num_el_i,
    input  logic signed [M_LEN-1:0] data_i,
    input  logic                    valid_i,
    output logic signed [M_LEN-1:0] data_o,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic                    done_o,
    output npu_bias_state_t         dbg_state_o
);

    npu_bias_state_t state_q, state_d;

    logic [AW:0]             num_ch_q;
    logic [CNT_W-1:0]        num_el_q;
    logic [AW-1:0]           ch_q;
    logic [CNT_W-1:0]        el_q;
    logic signed [M_LEN-1:0] bias_mem [BIAS_DEPTH];
    logic signed [M_LEN-1:0] bias_rd;
    logic signed [M_LEN:0]   sum_full;
    logic signed [M_LEN-1:0] sum_out;
    logic                    beat;
    logic                    last_ch;
    logic                    last_el;
    logic                    last_beat;
    logic                    wr_ok;

    // A zero-element pass consumes nothing, so beats are only taken when num_el is non-zero.
    assign beat      = (state_q == BIAS_RUN) && valid_i && (|num_el_q);
    assign last_ch   = ({1'b0, ch_q} == (num_ch_q - (AW+1)'(1)));
    assign last_el   = (el_q == (num_el_q - CNT_W'(1)));
    assign last_beat = beat && last_ch && last_el;
    assign wr_ok     = bias_we_i && (32'(bias_waddr_i) < BIAS_DEPTH);

    assign busy_o      = (state_q == BIAS_RUN);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BIAS_IDLE: if (start_i) state_d = BIAS_RUN;
            BIAS_RUN:  if (!(|num_el_q) || last_beat) state_d = BIAS_DONE;
            BIAS_DONE: state_d = BIAS_IDLE;
            default:   state_d = BIAS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= BIAS_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            num_ch_q <= (AW+1)'(1);
            num_el_q <= '0;
            ch_q     <= '0;
            el_q     <= '0;
        end else if ((state_q == BIAS_IDLE) && start_i) begin
            num_ch_q <= (num_ch_i == '0) ? (AW+1)'(1) : num_ch_i;
            num_el_q <= num_el_i;
            ch_q     <= '0;
            el_q     <= '0;
        end else if (beat) begin
            if (last_ch) begin
                ch_q <= '0;
                el_q <= last_el ? '0 : el_q + CNT_W'(1);
            end else begin
                ch_q <= ch_q + AW'(1);
            end
        end
    end

    // Read is combinational from the registered table, so a same-cycle write is seen only next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BIAS_DEPTH; i++) bias_mem[i] <= '0;
        end else if (wr_ok) begin
            bias_mem[bias_waddr_i] <= bias_wdata_i;
        end
    end

    assign bias_rd = bias_mem[ch_q];

    npu_bi_o u_bi_o (
        .data_i (data_i),
        .bias_i (bias_rd),
        .sum_o  (sum_full)
    );

    always_comb begin
        sum_out = sum_full[M_LEN-1:0];
`ifdef NPU_BIAS_SAT_EN
        // Overflow shows as a disagreement between the guard bit and the result sign bit.
        if (sum_full[M_LEN] != sum_full[M_LEN-1]) begin
            sum_out = sum_full[M_LEN] ? {1'b1, {(M_LEN-1){1'b0}}} : {1'b0, {(M_LEN-1){1'b1}}};
        end
`else
        sum_out = sum_full[M_LEN-1:0];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            done_o  <= 1'b0;
        end else begin
            valid_o <= beat;
            if (beat) data_o <= sum_out;
            done_o  <= (state_q == BIAS_DONE);
        end
    end

endmodule

// File: tb/tb_npu_bias_ctrl.sv
// Scoreboard bench for npu_bias_ctrl: directed passes plus randomized passes against an arithmetic model.
module tb_npu_bias_ctrl;
    import npu_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    bias_we_i = 1'b0;
    logic [AW-1:0]           bias_waddr_i = '0;
    logic signed [M_LEN-1:0] bias_wdata_i = '0;
    logic                    start_i = 1'b0;
    logic [AW:0]             num_ch_i = '0;
    logic [CW-1:0]           num_el_i = '0;
    logic signed [M_LEN-1:0] data_i = '0;
    logic                    valid_i = 1'b0;
    logic signed [M_LEN-1:0] data_o;
    logic                    valid_o;
    logic                    busy_o;
    logic                    done_o;
    npu_bias_state_t         dbg_state;

    npu_bias_ctrl #(.BIAS_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bias_we_i    (bias_we_i),
        .bias_waddr_i (bias_waddr_i),
        .bias_wdata_i (bias_wdata_i),
        .start_i      (start_i),
        .num_ch_i     (num_ch_i),
        .num_el_i     (num_el_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // scoreboard state and reference model
    logic [M_LEN-1:0] exp_q[$];
    int               exp_cyc_q[$];
    int               exp_done = -1;
    int               mb[DEPTH];
    bit               active = 1'b0;
    int               mch = 1;
    int               mel = 0;
    int               mbeat = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int ref_sum(input int d, input int b);
        int s;
        logic [M_LEN-1:0] t;
        s = d + b;
`ifdef NPU_BIAS_SAT_EN
        if (s > (1 << (M_LEN-1)) - 1) s = (1 << (M_LEN-1)) - 1;
        if (s < -(1 << (M_LEN-1)))    s = -(1 << (M_LEN-1));
        return s;
`else
        t = M_LEN'(s);
        return int'($signed(t));
`endif
    endfunction

    function automatic int rand_data();
        logic [M_LEN-1:0] r;
        r = M_LEN'($urandom);
        return int'($signed(r));
    endfunction

    // monitor
    initial begin
        logic [M_LEN-1:0] e;
        int c;
        forever begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious valid_o", int'(valid_o), 0);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("data_o", int'(data_o), int'($signed(e)));
                    check("valid_o latency", cyc, c);
                end
            end
            if (done_o === 1'b1) begin
                check("done_o timing", cyc, exp_done);
                exp_done = -1;
            end
        end
    end

    // driver tasks
    task automatic drive(input bit v, input int d, input bit we, input int wa, input int wd, input bit st);
        int ch;
        @(negedge clk);
        #1;
        if (active) check("busy_o in RUN", int'(busy_o), 1);
        valid_i      = v;
        data_i       = M_LEN'(d);
        bias_we_i    = we;
        bias_waddr_i = AW'(wa);
        bias_wdata_i = M_LEN'(wd);
        start_i      = st;
        if (v && active) begin
            ch = mbeat % mch;
            exp_q.push_back(M_LEN'(ref_sum(d, mb[ch])));
            exp_cyc_q.push_back(cyc + 1);
            mbeat++;
            if (mbeat == mch * mel) begin
                active   = 1'b0;
                exp_done = cyc + 2;
            end
        end
        if (we && wa < DEPTH) mb[wa] = wd;
    endtask

    task automatic beat(input bit v, input int d);
        drive(v, d, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int wa, input int wd);
        drive(1'b0, 0, 1'b1, wa, wd, 1'b0);
    endtask

    task automatic start_pass(input int nch, input int nel);
        @(negedge clk);
        #1;
        valid_i   = 1'b0;
        bias_we_i = 1'b0;
        start_i   = 1'b1;
        num_ch_i  = (AW+1)'(nch);
        num_el_i  = CW'(nel);
        mch       = (nch == 0) ? 1 : nch;
        mel       = nel;
        mbeat     = 0;
        if (nel == 0) begin
            active   = 1'b0;
            exp_done = cyc + 3;
        end else begin
            active = 1'b1;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_done != -1 || exp_q.size() != 0) && n < 40) begin
            beat(1'b0, 0);
            n++;
        end
        check("pass completes", int'(exp_done == -1 && exp_q.size() == 0), 1);
        beat(1'b0, 0);
        beat(1'b0, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1;
        rst       = 1'b1;
        valid_i   = 1'b1;
        data_i    = M_LEN'(rand_data());
        start_i   = 1'b0;
        bias_we_i = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_done = -1;
        active   = 1'b0;
        for (int i = 0; i < DEPTH; i++) mb[i] = 0;
        @(negedge clk);
        #1;
        check("reset valid_o", int'(valid_o), 0);
        check("reset done_o", int'(done_o), 0);
        check("reset busy_o", int'(busy_o), 0);
        check("reset data_o", int'(data_o), 0);
        check("reset state", int'(dbg_state), int'(BIAS_IDLE));
        rst     = 1'b0;
        valid_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nch, nel, d;
        for (int i = 0; i < DEPTH; i++) mb[i] = 0;
        reset_dut();

        // basic pass
        wr(0, 10); wr(1, -3); wr(2, 7);
        beat(1'b1, 55);  // idle beat, must be dropped
        start_pass(3, 2);
        for (int k = 1; k <= 6; k++) beat(1'b1, k);
        wait_done();

        // gapped input, with an ignored start in the middle
        start_pass(3, 2);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, k, 1'b0, 0, 0, k == 3);
            beat(1'b0, 0);
        end
        wait_done();

        // zero-element pass
        start_pass(2, 0);
        beat(1'b1, 9);
        wait_done();

        // overflow in both directions
        wr(0, 1); wr(1, -1);
        start_pass(2, 1);
        beat(1'b1, 32767);
        beat(1'b1, -32768);
        wait_done();

        // write collision: old bias this pass, new bias next pass
        wr(0, 100); wr(1, 200); wr(2, 300);
        start_pass(3, 1);
        beat(1'b1, 1);
        drive(1'b1, 2, 1'b1, 1, 99, 1'b0);
        beat(1'b1, 3);
        wait_done();
        start_pass(3, 1);
        for (int k = 1; k <= 3; k++) beat(1'b1, k);
        wait_done();

        // mid-pass reset, then a clean pass sees an all-zero table
        start_pass(3, 2);
        beat(1'b1, 1);
        beat(1'b1, 2);
        reset_dut();
        for (int k = 0; k < 4; k++) beat(1'b0, 0);
        start_pass(3, 1);
        for (int k = 7; k <= 9; k++) beat(1'b1, k);
        wait_done();

        // randomized passes
        for (int p = 0; p < 25; p++) begin
            for (int k = 0; k < 4; k++) wr($urandom_range(0, DEPTH-1), rand_data());
            nch = $urandom_range(0, DEPTH);
            nel = $urandom_range(0, 3);
            start_pass(nch, nel);
            while (active) begin
                d = rand_data();
                if ($urandom_range(0, 3) == 0) begin
                    drive(1'b0, d, 1'b0, 0, 0, 1'b0);
                end else if ($urandom_range(0, 4) == 0) begin
                    drive(1'b1, d, 1'b1, $urandom_range(0, DEPTH-1), rand_data(), 1'b0);
                end else begin
                    beat(1'b1, d);
                end
            end
            wait_done();
        end

        check("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
